alu_req_arbiter: RTL and testbench

- Shares one registered 4-bit ALU between two independent requesters.
- Arbitration is round-robin; each request uses a valid/ready handshake, and the result returns on the granted requester's response channel.
- At most one operation is in flight at a time.
- Sits between the host-side command sources and the ALU datapath, replacing direct pin drive of the opcode and operands.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu4_func.sv | 50 +++++
 rtl/alu_req_arbiter.sv | 107 ++++++++++
 tb/tb_alu_req_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated 4-bit ALU: opcodes, FSM states,
// the registered result record and the round-robin pick helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_ENC = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       ovf;
        logic       err;
    } alu_res_t;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last);
        if (valid == 2'b11) begin
            return ~last;
        end
        return valid[1];
    endfunction

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu4_func.sv
// Combinational 4-bit ALU: maps opcode and operands to result/carry/ovf/err.
module alu4_func
    import alu_pkg::*;
#(
    parameter logic [7:0] ENC_KEY = 8'hAB
) (
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output alu_res_t   res
);

    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        case (op)
            OP_ADD: begin
                res.result = {4'h0, sum[3:0]};
                res.carry  = sum[4];
                res.ovf    = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            OP_SUB: begin
                // diff[4] is the borrow; carry reports not-borrow
                res.result = {4'h0, diff[3:0]};
                res.carry  = ~diff[4];
                res.ovf    = (a[3] != b[3]) && (diff[3] != a[3]);
            end
            OP_MUL: res.result = {4'h0, a} * {4'h0, b};
            OP_DIV: begin
                if (b == 4'h0) begin
                    res.err = 1'b1;
                end else begin
                    res.result = {a % b, a / b};
                end
            end
            OP_AND: res.result = {4'h0, a & b};
            OP_OR:  res.result = {4'h0, a | b};
            OP_XOR: res.result = {4'h0, a ^ b};
            OP_NOT: res.result = {4'h0, ~a};
            OP_ENC: res.result = {a, b} ^ ENC_KEY;
            default: res.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit ALU between two requesters,
// with one operation in flight and results returned on the owner's channel.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter logic [7:0] ENC_KEY = 8'hAB,
    parameter logic       RR_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_op0,
    input  logic [3:0] req_op1,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_b1,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [7:0] resp_result,
    output logic       resp_carry,
    output logic       resp_ovf,
    output logic       resp_err,
    output logic       resp_id,
    output logic       busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the sender holds its payload until then and may drop
    // valid beforehand, in which case nothing is transferred.
    arb_state_t state;
    logic       last_grant;
    logic       grant;
    logic       cmd_id;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    alu_res_t   alu_res;

    assign grant     = rr_pick(req_valid, last_grant);
    assign req_ready = ((state == ST_IDLE) && (req_valid != 2'b00)) ? idx_onehot(grant) : 2'b00;

    alu4_func #(
        .ENC_KEY (ENC_KEY)
    ) u_alu (
        .op  (cmd_op),
        .a   (cmd_a),
        .b   (cmd_b),
        .res (alu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= RR_INIT;
            cmd_id      <= 1'b0;
            cmd_op      <= 4'h0;
            cmd_a       <= 4'h0;
            cmd_b       <= 4'h0;
            resp_valid  <= 2'b00;
            resp_result <= 8'h00;
            resp_carry  <= 1'b0;
            resp_ovf    <= 1'b0;
            resp_err    <= 1'b0;
            resp_id     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Any valid request is accepted: req_ready follows the grant.
                    if (req_valid != 2'b00) begin
                        cmd_id <= grant;
                        cmd_op <= grant ? req_op1 : req_op0;
                        cmd_a  <= grant ? req_a1  : req_a0;
                        cmd_b  <= grant ? req_b1  : req_b0;
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result <= alu_res.result;
                    resp_carry  <= alu_res.carry;
                    resp_ovf    <= alu_res.ovf;
                    resp_err    <= alu_res.err;
                    resp_id     <= cmd_id;
                    resp_valid  <= idx_onehot(cmd_id);
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[resp_id]) begin
                        resp_valid <= 2'b00;
                        last_grant <= resp_id;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 2'b00;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_req_arbiter;

    localparam logic [7:0] ENC_KEY = 8'hAB;
    localparam int W = 12;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_op0, req_op1, req_a0, req_a1, req_b0, req_b1;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [7:0] resp_result;
    logic       resp_carry, resp_ovf, resp_err, resp_id, busy;

    alu_req_arbiter #(
        .ENC_KEY (ENC_KEY),
        .RR_INIT (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_ovf    (resp_ovf),
        .resp_err    (resp_err),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU: {err, ovf, carry, result[7:0]} from plain integer arithmetic.
    function automatic logic [10:0] alu_ref(input int op, input int a, input int b);
        int r, sa, sb;
        bit c, o, e;
        r = 0; c = 0; o = 0; e = 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        case (op)
            0: begin
                r = (a + b) % 16;
                c = (a + b) >= 16;
                o = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            1: begin
                r = (a - b + 16) % 16;
                c = (a >= b);
                o = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
            2: r = a * b;
            3: if (b == 0) e = 1; else r = (a % b) * 16 + a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = 15 - a;
            8: r = (a * 16 + b) ^ int'(ENC_KEY);
            default: e = 1;
        endcase
        return {e, o, c, r[7:0]};
    endfunction

    // Outstanding transaction: {id, err, ovf, carry, result}, plus the cycle
    // at which its response must appear.
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    logic         m_last = 1'b1;
    logic [1:0]   took = 2'b00;

    initial forever begin
        logic       idle, g, rv;
        logic [1:0] e_ready, e_rvalid;
        logic [W-1:0] item;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            m_last = 1'b1;
            took   = 2'b00;
            chk("rst_req_ready",  32'(req_ready),   32'd0);
            chk("rst_resp_valid", 32'(resp_valid),  32'd0);
            chk("rst_result",     32'(resp_result), 32'd0);
            chk("rst_flags",      32'({resp_carry, resp_ovf, resp_err, resp_id}), 32'd0);
            chk("rst_busy",       32'(busy),        32'd0);
        end else begin
            idle = (exp_q.size() == 0);
            g    = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            e_ready = (idle && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            item = '0;
            rv   = 1'b0;
            if (!idle) begin
                item = exp_q[0];
                rv   = (cyc >= due_q[0]);
            end
            e_rvalid = rv ? (item[11] ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready",  32'(req_ready),  32'(e_ready));
            chk("busy",       32'(busy),       32'(!idle));
            chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
            if (rv) begin
                chk("resp_result", 32'(resp_result), 32'(item[7:0]));
                chk("resp_carry",  32'(resp_carry),  32'(item[8]));
                chk("resp_ovf",    32'(resp_ovf),    32'(item[9]));
                chk("resp_err",    32'(resp_err),    32'(item[10]));
                chk("resp_id",     32'(resp_id),     32'(item[11]));
            end
            took = e_ready;
            if (e_ready != 2'b00) begin
                if (g) exp_q.push_back({1'b1, alu_ref(int'(req_op1), int'(req_a1), int'(req_b1))});
                else   exp_q.push_back({1'b0, alu_ref(int'(req_op0), int'(req_a0), int'(req_b0))});
                due_q.push_back(cyc + 2);
            end
            if (rv && resp_ready[item[11]]) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                m_last = item[11];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input int op, input int a, input int b);
        if (id == 0) begin
            req_op0 = 4'(op); req_a0 = 4'(a); req_b0 = 4'(b);
        end else begin
            req_op1 = 4'(op); req_a1 = 4'(a); req_b1 = 4'(b);
        end
    endtask

    // Waits for the accept of requester id; returns at posedge+1 after it.
    task automatic wait_hs(input int id, output int t_hs);
        bit seen = 0;
        t_hs = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                seen = 1;
                t_hs = cyc;
                break;
            end
        end
        chk("hs_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int op, input int a, input int b, output int t_hs);
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        wait_hs(id, t_hs);
        req_valid[id] = 1'b0;
    endtask

    task automatic expect_resp(input int id, input logic [7:0] r, input logic c, input logic o,
                               input logic e, input int t_hs);
        bit seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (resp_valid[id]) begin
                seen = 1;
                break;
            end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("lat",     32'(cyc - t_hs), 32'd2);
            chk("lit_res", 32'(resp_result), 32'(r));
            chk("lit_flg", 32'({resp_carry, resp_ovf, resp_err}), 32'({c, o, e}));
            chk("lit_id",  32'(resp_id), 32'(id));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, k;
        int ids[4], ress[4], tms[4];

        rst = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);

        // pin the reference model itself
        chk("model_add", 32'(alu_ref(0, 9, 8)),  32'h301);
        chk("model_sub", 32'(alu_ref(1, 3, 5)),  32'h00E);
        chk("model_mul", 32'(alu_ref(2, 15, 15)), 32'h0E1);
        chk("model_div0", 32'(alu_ref(3, 7, 0)), 32'h400);
        chk("model_enc", 32'(alu_ref(8, 1, 2)),  32'h0B9);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // tie after reset: requester 0 first, then the waiting requester 1
        set_req(0, 0, 9, 8);
        set_req(1, 1, 3, 5);
        req_valid = 2'b11;
        @(negedge clk);
        chk("first_tie", 32'(req_ready), 32'b01);
        wait_hs(0, t0);
        req_valid[0] = 1'b0;
        expect_resp(0, 8'h01, 1'b1, 1'b1, 1'b0, t0);
        wait_hs(1, t1);
        req_valid[1] = 1'b0;
        expect_resp(1, 8'h0E, 1'b0, 1'b0, 1'b0, t1);

        send(1, 2, 15, 15, t1);  expect_resp(1, 8'hE1, 1'b0, 1'b0, 1'b0, t1);
        send(0, 3, 13, 4, t0);   expect_resp(0, 8'h13, 1'b0, 1'b0, 1'b0, t0);
        send(0, 3, 7, 0, t0);    expect_resp(0, 8'h00, 1'b0, 1'b0, 1'b1, t0);
        send(1, 12, 6, 3, t1);   expect_resp(1, 8'h00, 1'b0, 1'b0, 1'b1, t1);

        // back-pressure on requester 0 with a stray ack from requester 1
        resp_ready = 2'b10;
        set_req(1, 6, 12, 10);
        send(0, 5, 10, 5, t0);
        req_valid[1] = 1'b1;
        expect_resp(0, 8'h0F, 1'b0, 1'b0, 1'b0, t0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_valid",  32'(resp_valid),  32'b01);
            chk("bp_result", 32'(resp_result), 32'h0F);
            chk("bp_ready",  32'(req_ready),   32'b00);
            chk("bp_busy",   32'(busy),        32'd1);
        end
        @(posedge clk);
        #1;
        resp_ready = 2'b11;
        @(negedge clk);
        chk("bp_release_valid", 32'(resp_valid), 32'b01);
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_busy",  32'(busy),      32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'b10);
        t1 = cyc;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        expect_resp(1, 8'h06, 1'b0, 1'b0, 1'b0, t1);

        // reset while an ADD is in EXEC
        send(0, 0, 7, 7, t0);
        chk("exec_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req_ready",  32'(req_ready),   32'd0);
        chk("async_resp_valid", 32'(resp_valid),  32'd0);
        chk("async_result",     32'(resp_result), 32'd0);
        chk("async_flags",      32'({resp_carry, resp_ovf, resp_err, resp_id}), 32'd0);
        chk("async_busy",       32'(busy),        32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // both valid continuously: strict alternation, one response per 3 cycles
        set_req(0, 8, 1, 2);
        set_req(1, 7, 5, 0);
        req_valid = 2'b11;
        k = 0;
        for (int n = 0; n < 40 && k < 4; n++) begin
            @(negedge clk);
            if (n == 0) chk("tie_after_rst", 32'(req_ready), 32'b01);
            if (resp_valid != 2'b00) begin
                ids[k]  = int'(resp_valid[1]);
                ress[k] = int'(resp_result);
                tms[k]  = cyc;
                k++;
            end
        end
        chk("alt_count", 32'(k), 32'd4);
        for (int j = 0; j < k; j++) begin
            chk("alt_id",  32'(ids[j]),  32'(j % 2));
            chk("alt_res", 32'(ress[j]), (j % 2 == 1) ? 32'h0A : 32'hB9);
            if (j > 0) chk("alt_gap", 32'(tms[j] - tms[j-1]), 32'd3);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !took[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    if (req_valid[i])
                        set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                end
            end
            resp_ready = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end

        req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (8) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
